// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and EPC, selects the next PC from
// NUM_SRC packed candidates, evaluates branch conditions and sequences
// exception entry (RUN -> VECTOR -> RUN) and return.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds align_err, blocks
// misaligned targets and turns a misaligned source write into a cause-3 trap).
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int               NUM_SRC    = 5,
  parameter int               SEL_W      = 3,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_BASE   = 'h0000_00FC,
  parameter int               EPC_OFFSET = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic [1:0]               cond_mode,
  input  logic                     zero,
  input  logic                     neg,
  input  logic                     exc_req,
  input  logic [1:0]               exc_cause,
  input  logic                     eret,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         epc,
  output logic [1:0]               cause_q,
  output logic                     exc_busy,
  output logic                     redirect,
`ifdef PC_ALIGN_CHECK_EN
  output logic                     sel_err,
  output logic                     align_err
`else
  output logic                     sel_err
`endif
);

  typedef enum logic {RUN, VECTOR} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt, epc_nxt, src_sel, vec_pc, epc_cap;
  logic [1:0]       cause_nxt;
  logic             cond_true, take, sel_ok;
  logic             pend, pend_nxt;

  // Branch condition decode and overall write enable.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond_mode)
      2'b00: cond_true = zero;
      2'b01: cond_true = ~zero;
      2'b10: cond_true = neg | zero;
      2'b11: cond_true = ~(neg | zero);
    endcase
    take = pc_write | (pc_write_cond & cond_true);
  end

  // Candidate mux; out-of-range selects flag an error instead of loading.
  always_comb begin
    src_sel = '0;
    sel_ok  = (int'(sel) < NUM_SRC);
    for (int i = 0; i < NUM_SRC; i++)
      if (int'(sel) == i) src_sel = src_bus[i*WIDTH +: WIDTH];
  end

  assign vec_pc  = EXC_BASE + (WIDTH'(cause_q) << 2);
  assign epc_cap = pc - WIDTH'(EPC_OFFSET);

  // Next-state, register updates and per-cycle pulses.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    cause_nxt = cause_q;
    pend_nxt  = 1'b0;
    exc_busy  = 1'b0;
    redirect  = 1'b0;
    sel_err   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    align_err = 1'b0;
`endif
    if (state == VECTOR) begin
      exc_busy  = 1'b1;
      state_nxt = RUN;
`ifdef PC_ALIGN_CHECK_EN
      if (vec_pc[1:0] != 2'b00) align_err = 1'b1;
      else begin pc_nxt = vec_pc; redirect = 1'b1; end
`else
      pc_nxt   = vec_pc;
      redirect = 1'b1;
`endif
    end else if (exc_req) begin
      epc_nxt   = epc_cap;
      cause_nxt = exc_cause;
      state_nxt = VECTOR;
    end else if (pend) begin
      // Deferred trap from last cycle's misaligned source write.
      epc_nxt   = epc_cap;
      cause_nxt = 2'b11;
      state_nxt = VECTOR;
    end else if (eret) begin
`ifdef PC_ALIGN_CHECK_EN
      if (epc[1:0] != 2'b00) align_err = 1'b1;
      else begin pc_nxt = epc; redirect = 1'b1; end
`else
      pc_nxt   = epc;
      redirect = 1'b1;
`endif
    end else if (take) begin
      if (!sel_ok) sel_err = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      else if (src_sel[1:0] != 2'b00) begin
        align_err = 1'b1;
        pend_nxt  = 1'b1;
      end
`endif
      else begin
        pc_nxt   = src_sel;
        redirect = 1'b1;
      end
    end
    if (reset) begin
      exc_busy = 1'b0;
      redirect = 1'b0;
      sel_err  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      align_err = 1'b0;
`endif
    end
  end

  // State and architectural registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      epc     <= '0;
      cause_q <= 2'b00;
      pend    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      epc     <= epc_nxt;
      cause_q <= cause_nxt;
      pend    <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0][31:0] src;
  logic [2:0]       sel;
  logic             pc_write, pc_write_cond, zero, neg, exc_req, eret;
  logic [1:0]       cond_mode, exc_cause;
  logic [31:0]      pc, epc;
  logic [1:0]       cause_q;
  logic             exc_busy, redirect, sel_err;
`ifdef PC_ALIGN_CHECK_EN
  logic             align_err;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .src_bus(src), .sel(sel),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_mode(cond_mode),
    .zero(zero), .neg(neg), .exc_req(exc_req), .exc_cause(exc_cause),
    .eret(eret), .pc(pc), .epc(epc), .cause_q(cause_q),
    .exc_busy(exc_busy), .redirect(redirect),
`ifdef PC_ALIGN_CHECK_EN
    .sel_err(sel_err), .align_err(align_err)
`else
    .sel_err(sel_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; src = '0; sel = 0; pc_write = 0; pc_write_cond = 0;
    cond_mode = 0; zero = 0; neg = 0; exc_req = 0; exc_cause = 0; eret = 0;
    src[0] = 32'h10; src[1] = 32'h100; src[2] = 32'h40;
    src[3] = 32'h208; src[4] = 32'h33C;
    step(); step();
    pc_write = 1; sel = 2; #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", 32'(cause_q), 32'h0);
    chk("rst_busy", 32'(exc_busy), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_selerr", 32'(sel_err), 32'h0);

    // plain write
    reset = 0; #1;
    chk("wr_redirect", 32'(redirect), 32'h1);
    step(); pc_write = 0; #1;
    chk("wr_pc", pc, 32'h40);
    chk("idle_redirect", 32'(redirect), 32'h0);

    // conditional: zero=0 not taken, then zero=1 taken
    pc_write_cond = 1; cond_mode = 2'b00; zero = 0; sel = 1; #1;
    chk("cond_nt_redirect", 32'(redirect), 32'h0);
    step();
    chk("cond_nt_pc", pc, 32'h40);
    zero = 1; #1;
    chk("cond_t_redirect", 32'(redirect), 32'h1);
    step();
    chk("cond_t_pc", pc, 32'h100);
    // mode 01 with zero=1: not taken
    cond_mode = 2'b01; sel = 3; step();
    chk("cond01_pc", pc, 32'h100);
    // mode 11 with neg=1: not taken
    cond_mode = 2'b11; zero = 0; neg = 1; step();
    chk("cond11_pc", pc, 32'h100);
    // mode 10 with neg=1: taken
    cond_mode = 2'b10; step();
    chk("cond10_pc", pc, 32'h208);
    pc_write_cond = 0; neg = 0;

    // exception entry with a simultaneous write that must be dropped
    exc_req = 1; exc_cause = 1; pc_write = 1; sel = 0; #1;
    chk("exc_redirect", 32'(redirect), 32'h0);
    step();
    exc_req = 0; eret = 1; #1;  // pc_write/eret ignored in VECTOR
    chk("vec_epc", epc, 32'h204);
    chk("vec_cause", 32'(cause_q), 32'h1);
    chk("vec_busy", 32'(exc_busy), 32'h1);
    chk("vec_pc_hold", pc, 32'h208);
    chk("vec_redirect", 32'(redirect), 32'h1);
    step();
    pc_write = 0; eret = 0; #1;
    chk("vec_pc", pc, 32'h100);
    chk("run_busy", 32'(exc_busy), 32'h0);

    // eret
    eret = 1; step(); eret = 0; #1;
    chk("eret_pc", pc, 32'h204);
    chk("eret_epc", epc, 32'h204);

    // out-of-range select
    pc_write = 1; sel = 7; #1;
    chk("selerr_pulse", 32'(sel_err), 32'h1);
    chk("selerr_redirect", 32'(redirect), 32'h0);
    step(); pc_write = 0; #1;
    chk("selerr_pc", pc, 32'h204);
    chk("selerr_clear", 32'(sel_err), 32'h0);

    // reset while in VECTOR
    exc_req = 1; exc_cause = 2; step();
    exc_req = 0; reset = 1; #1;
    chk("rstvec_busy", 32'(exc_busy), 32'h0);
    step(); reset = 0; #1;
    chk("rstvec_pc", pc, 32'h0);
    chk("rstvec_epc", epc, 32'h0);
    step();
    chk("rstvec_noload", pc, 32'h0);

    // epc wrap-around and cause-3 vector
    exc_req = 1; exc_cause = 3; step(); exc_req = 0; #1;
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    step();
    chk("vec3_pc", pc, 32'h108);

    // both enables high act as a plain write
    pc_write = 1; pc_write_cond = 1; cond_mode = 0; zero = 0; sel = 4;
    step(); pc_write = 0; pc_write_cond = 0; #1;
    chk("both_pc", pc, 32'h33C);

`ifdef PC_ALIGN_CHECK_EN
    src[0] = 32'h102; pc_write = 1; sel = 0; #1;
    chk("al_err", 32'(align_err), 32'h1);
    chk("al_redirect", 32'(redirect), 32'h0);
    step(); pc_write = 0; #1;
    chk("al_pc_hold", pc, 32'h33C);
    step();
    chk("al_epc", epc, 32'h338);
    chk("al_cause", 32'(cause_q), 32'h3);
    chk("al_busy", 32'(exc_busy), 32'h1);
    step();
    chk("al_vec_pc", pc, 32'h108);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
